// File: rtl/adain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adain_ctrl
// Purpose  : Phase sequencer for the AdaIN datapath (statistics and
//            normalise commands over one feature map).
// Revision : 1.0 - initial release
// ============================================================================
module adain_ctrl #(
    parameter int N_MAX   = 256,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 1,
    parameter int ADDR_W  = $clog2(N_MAX)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   start,
    input  logic [$clog2(N_MAX+1)-1:0]   N,
    output logic [2:0]                   state,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic                         input_mac_en,
    output logic                         zero_op,
    output logic                         rst_acc,
    output logic                         mean_en,
    output logic                         variance_en,
    output logic                         inv_sigma_en,
    output logic                         B1_en,
    output logic                         B0_en,
    output logic                         out_en,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         stats_valid,
    output logic [1:0]                   done
);

    localparam int NW    = $clog2(N_MAX+1);
    localparam int CNT_W = $clog2(N_MAX+RD_LAT+MAC_LAT+3);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_mean    = 3'd1;
    localparam logic [2:0] c_var     = 3'd2;
    localparam logic [2:0] c_invsqrt = 3'd3;
    localparam logic [2:0] c_b1      = 3'd4;
    localparam logic [2:0] c_b0      = 3'd5;
    localparam logic [2:0] c_out     = 3'd6;

    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_rd_lat  = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] c_mac_lat = CNT_W'(MAC_LAT);

    logic [2:0]        r_phase;
    logic [CNT_W-1:0]  r_cnt;
    logic [NW-1:0]     r_n;
    logic              r_stats_valid;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_mac_en;
    logic              r_zero_op;
    logic              r_rst_acc;
    logic              r_mean_en;
    logic              r_var_en;
    logic              r_inv_en;
    logic              r_b1_en;
    logic              r_b0_en;
    logic              r_out_en;
    logic              r_out_valid;
    logic [1:0]        r_done;

    logic [2:0]        w_phase_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [NW-1:0]     w_n_nxt;
    logic              w_sv_nxt;
    logic              w_done0_nxt;

    logic [CNT_W-1:0]  w_n_cur;
    logic              w_stream_last;
    logic              w_single_last;
    logic              w_out_last;

    assign w_n_cur       = CNT_W'(r_n);
    assign w_stream_last = (r_cnt == c_rd_lat + w_n_cur + c_mac_lat);
    assign w_single_last = (r_cnt == c_mac_lat + c_one);
    assign w_out_last    = (r_cnt == c_rd_lat + c_mac_lat + c_one + w_n_cur);

    // Next phase / offset; a new phase always restarts the offset at zero.
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + c_one;
        w_n_nxt     = r_n;
        w_sv_nxt    = r_stats_valid;
        w_done0_nxt = 1'b0;
        case (r_phase)
            c_idle: begin
                w_cnt_nxt = '0;
                if (start[0] && (N != '0)) begin
                    w_phase_nxt = c_mean;
                    w_n_nxt     = N;
                    w_sv_nxt    = 1'b0;
                end else if (start[1] && (N != '0) && r_stats_valid) begin
                    w_phase_nxt = c_out;
                    w_n_nxt     = N;
                end
            end
            c_mean: if (w_stream_last) begin
                w_phase_nxt = c_var;
                w_cnt_nxt   = '0;
            end
            c_var: if (w_stream_last) begin
                w_phase_nxt = c_invsqrt;
                w_cnt_nxt   = '0;
            end
            c_invsqrt: if (w_single_last) begin
                w_phase_nxt = c_b1;
                w_cnt_nxt   = '0;
            end
            c_b1: if (w_single_last) begin
                w_phase_nxt = c_b0;
                w_cnt_nxt   = '0;
            end
            c_b0: if (w_single_last) begin
                w_phase_nxt = c_idle;
                w_cnt_nxt   = '0;
                w_sv_nxt    = 1'b1;
                w_done0_nxt = 1'b1;
            end
            c_out: if (w_out_last) begin
                w_phase_nxt = c_idle;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_phase_nxt = c_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming phase/offset so they register in step with it.
    logic [CNT_W-1:0] w_nn;
    logic             w_stream;
    logic             w_single;
    logic             w_valid_op;
    logic             w_cap_stream;
    logic             w_cap_single;
    logic             w_rd_en;
    logic             w_zero_op;
    logic             w_rst_acc;
    logic             w_out_en;
    logic             w_done1;

    assign w_nn         = CNT_W'(w_n_nxt);
    assign w_stream     = (w_phase_nxt == c_mean) || (w_phase_nxt == c_var) ||
                          (w_phase_nxt == c_out);
    assign w_single     = (w_phase_nxt == c_invsqrt) || (w_phase_nxt == c_b1) ||
                          (w_phase_nxt == c_b0);
    assign w_valid_op   = (w_cnt_nxt >= c_rd_lat) && (w_cnt_nxt < c_rd_lat + w_nn);
    assign w_cap_stream = (w_cnt_nxt == c_rd_lat + w_nn + c_mac_lat);
    assign w_cap_single = (w_cnt_nxt == c_mac_lat + c_one);
    assign w_rd_en      = w_stream && (w_cnt_nxt < w_nn);
    assign w_zero_op    = w_stream ? !w_valid_op : (w_single && (w_cnt_nxt != '0));
    assign w_rst_acc    = (w_phase_nxt == c_out) ? w_valid_op :
                          ((w_phase_nxt == c_mean) || (w_phase_nxt == c_var)) ?
                              (w_cnt_nxt == c_rd_lat) :
                          (w_single && (w_cnt_nxt == '0));
    assign w_out_en     = (w_phase_nxt == c_out) &&
                          (w_cnt_nxt >= c_rd_lat + c_mac_lat + c_one) &&
                          (w_cnt_nxt <  c_rd_lat + c_mac_lat + c_one + w_nn);
    assign w_done1      = (w_phase_nxt == c_out) &&
                          (w_cnt_nxt == c_rd_lat + c_mac_lat + c_one + w_nn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase       <= c_idle;
            r_cnt         <= '0;
            r_n           <= '0;
            r_stats_valid <= 1'b0;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_mac_en      <= 1'b0;
            r_zero_op     <= 1'b0;
            r_rst_acc     <= 1'b0;
            r_mean_en     <= 1'b0;
            r_var_en      <= 1'b0;
            r_inv_en      <= 1'b0;
            r_b1_en       <= 1'b0;
            r_b0_en       <= 1'b0;
            r_out_en      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_done        <= 2'b00;
        end else begin
            r_phase       <= w_phase_nxt;
            r_cnt         <= w_cnt_nxt;
            r_n           <= w_n_nxt;
            r_stats_valid <= w_sv_nxt;
            r_rd_en       <= w_rd_en;
            r_rd_addr     <= w_rd_en ? w_cnt_nxt[ADDR_W-1:0] : '0;
            r_mac_en      <= (w_phase_nxt != c_idle);
            r_zero_op     <= w_zero_op;
            r_rst_acc     <= w_rst_acc;
            r_mean_en     <= (w_phase_nxt == c_mean) && w_cap_stream;
            r_var_en      <= (w_phase_nxt == c_var) && w_cap_stream;
            r_inv_en      <= (w_phase_nxt == c_invsqrt) && w_cap_single;
            r_b1_en       <= (w_phase_nxt == c_b1) && w_cap_single;
            r_b0_en       <= (w_phase_nxt == c_b0) && w_cap_single;
            r_out_en      <= w_out_en;
            r_out_valid   <= r_out_en;
            r_done        <= {w_done1, w_done0_nxt};
        end
    end

    assign state        = r_phase;
    assign busy         = (r_phase != c_idle);
    assign stats_valid  = r_stats_valid;
    assign rd_en        = r_rd_en;
    assign rd_addr      = r_rd_addr;
    assign input_mac_en = r_mac_en;
    assign zero_op      = r_zero_op;
    assign rst_acc      = r_rst_acc;
    assign mean_en      = r_mean_en;
    assign variance_en  = r_var_en;
    assign inv_sigma_en = r_inv_en;
    assign B1_en        = r_b1_en;
    assign B0_en        = r_b0_en;
    assign out_en       = r_out_en;
    assign out_valid    = r_out_valid;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_adain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adain_ctrl
// Purpose  : Scoreboard bench for adain_ctrl; expected per-cycle outputs are
//            built from the command timelines when a command is issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adain_ctrl;

    localparam int N_MAX   = 256;
    localparam int RD_LAT  = 1;
    localparam int MAC_LAT = 1;
    localparam int ADDR_W  = 8;
    localparam int NW      = 9;
    localparam int NEVER   = 32'h7fff_ffff;

    logic              clk;
    logic              rst;
    logic [1:0]        start;
    logic [NW-1:0]     N;
    logic [2:0]        state;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              input_mac_en, zero_op, rst_acc;
    logic              mean_en, variance_en, inv_sigma_en, B1_en, B0_en;
    logic              out_en, out_valid, busy, stats_valid;
    logic [1:0]        done;

    adain_ctrl #(.N_MAX(N_MAX), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .N(N), .state(state),
        .rd_en(rd_en), .rd_addr(rd_addr), .input_mac_en(input_mac_en),
        .zero_op(zero_op), .rst_acc(rst_acc), .mean_en(mean_en),
        .variance_en(variance_en), .inv_sigma_en(inv_sigma_en),
        .B1_en(B1_en), .B0_en(B0_en), .out_en(out_en), .out_valid(out_valid),
        .busy(busy), .stats_valid(stats_valid), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        st;
        logic              bsy;
        logic              sv;
        logic [1:0]        dn;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic              mac, zop, racc;
        logic              m_en, v_en, i_en, b1, b0, oe, ov;
    } ovec_t;

    typedef struct {
        int    cyc;
        ovec_t v;
        ovec_t m;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_r;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   free_from = 0;
    int   sv_cycle = NEVER;
    bit   idle_sv = 1'b0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ovec_t actual();
        ovec_t a;
        a.st = state;  a.bsy = busy;  a.sv = stats_valid;  a.dn = done;
        a.rd = rd_en;  a.addr = rd_addr;  a.mac = input_mac_en;
        a.zop = zero_op;  a.racc = rst_acc;  a.m_en = mean_en;
        a.v_en = variance_en;  a.i_en = inv_sigma_en;  a.b1 = B1_en;
        a.b0 = B0_en;  a.oe = out_en;  a.ov = out_valid;
        return a;
    endfunction

    function automatic rec_t busy_rec(int c, logic [2:0] code, bit sv);
        rec_t r;
        r.cyc = c;
        r.v = '0;  r.v.st = code;  r.v.bsy = 1'b1;  r.v.sv = sv;
        r.v.mac = 1'b1;  r.v.zop = 1'b1;
        r.m = '1;  r.m.addr = '0;
        return r;
    endfunction

    // MEAN / VAR / OUT timeline; returns the phase length.
    function automatic int gen_stream(int t0, int n, logic [2:0] code);
        rec_t e[];
        bit   is_out = (code == 3'd6);
        int   len = RD_LAT + n + MAC_LAT + 1 + (is_out ? 1 : 0);
        e = new[len];
        for (int i = 0; i < len; i++) e[i] = busy_rec(t0 + i, code, is_out);
        for (int k = 0; k < n; k++) begin
            e[k].v.rd = 1'b1;
            e[k].v.addr = ADDR_W'(k);
            e[k].m.addr = '1;
            e[RD_LAT + k].v.zop = 1'b0;
            if (is_out) begin
                e[RD_LAT + k].v.racc = 1'b1;
                e[RD_LAT + MAC_LAT + 1 + k].v.oe = 1'b1;
                e[RD_LAT + MAC_LAT + 2 + k].v.ov = 1'b1;
            end
        end
        if (is_out) e[len-1].v.dn[1] = 1'b1;
        else e[RD_LAT].v.racc = 1'b1;
        if (code == 3'd1) e[len-1].v.m_en = 1'b1;
        if (code == 3'd2) e[len-1].v.v_en = 1'b1;
        for (int i = 0; i < len; i++) exp_q.push_back(e[i]);
        return len;
    endfunction

    function automatic int gen_single(int t0, logic [2:0] code);
        rec_t e[];
        int   len = MAC_LAT + 2;
        e = new[len];
        for (int i = 0; i < len; i++) e[i] = busy_rec(t0 + i, code, 1'b0);
        e[0].v.zop = 1'b0;
        e[0].v.racc = 1'b1;
        e[len-1].m.mac = 1'b0;
        e[len-1].m.zop = 1'b0;
        case (code)
            3'd3:    e[len-1].v.i_en = 1'b1;
            3'd4:    e[len-1].v.b1 = 1'b1;
            default: e[len-1].v.b0 = 1'b1;
        endcase
        for (int i = 0; i < len; i++) exp_q.push_back(e[i]);
        return len;
    endfunction

    task automatic model_stats(int t0, int n);
        rec_t r;
        int   t = t0;
        t += gen_stream(t, n, 3'd1);
        t += gen_stream(t, n, 3'd2);
        t += gen_single(t, 3'd3);
        t += gen_single(t, 3'd4);
        t += gen_single(t, 3'd5);
        r.cyc = t;  r.v = '0;  r.v.dn = 2'b01;  r.v.sv = 1'b1;
        r.m = '1;  r.m.addr = '0;
        exp_q.push_back(r);
        free_from = t;
        sv_cycle = t;
    endtask

    task automatic model_out(int t0, int n);
        free_from = t0 + gen_stream(t0, n, 3'd6);
    endtask

    // Issue one start pulse; the model decides acceptance from its own view of time.
    task automatic cmd(logic [1:0] s, int n);
        @(negedge clk);
        start = s;
        N = NW'(n);
        if (cyc >= free_from) begin
            if (s[0] && n != 0) model_stats(cyc + 1, n);
            else if (s[1] && n != 0 && cyc >= sv_cycle) model_out(cyc + 1, n);
        end
        @(negedge clk);
        start = 2'b00;
    endtask

    task automatic wait_idle();
        int b = 0;
        while (cyc <= free_from && b < 5000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: timed out at cycle %0d, required idle by %0d", cyc, free_from);
        end
    endtask

    task automatic reset_now();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (actual() != '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs %h, required 0", actual());
        end
        exp_q.delete();
        free_from = 0;
        sv_cycle = NEVER;
        idle_sv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every active cycle is compared against the scoreboard or idle values.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_r = exp_q.pop_front();
                idle_sv = mon_r.v.sv;
            end else begin
                mon_r.cyc = cyc;
                mon_r.v = '0;
                mon_r.v.sv = idle_sv;
                mon_r.m = '1;
                mon_r.m.addr = '0;
            end
            n_checks++;
            if (((actual() ^ mon_r.v) & mon_r.m) != '0) begin
                n_fail++;
                $display("FAIL cycle_outputs @%0d: got %h required %h (care %h)",
                         cyc, actual(), mon_r.v, mon_r.m);
            end
        end
    end

    initial begin
        rst = 1'b0;
        start = 2'b00;
        N = '0;
        #1;
        n_checks++;
        if (actual() != '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs %h, required 0", actual());
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Ignored commands: normalise without stats, zero length.
        cmd(2'b10, 4);
        cmd(2'b01, 0);
        cmd(2'b10, 0);
        repeat (3) @(negedge clk);

        // Abort mid-MEAN, then a clean run.
        cmd(2'b01, 4);
        repeat (2) @(negedge clk);
        @(posedge clk);
        reset_now();
        cmd(2'b01, 4);
        repeat (2) @(negedge clk);
        cmd(2'b01, 4);
        cmd(2'b10, 4);
        wait_idle();
        repeat (5) @(negedge clk);
        cmd(2'b10, 4);
        wait_idle();

        // Both bits: statistics wins, then a fresh normalise.
        cmd(2'b11, 5);
        wait_idle();
        cmd(2'b10, 3);
        wait_idle();

        // Largest map.
        cmd(2'b01, N_MAX);
        wait_idle();
        cmd(2'b10, N_MAX);
        wait_idle();

        for (int it = 0; it < 60; it++) begin
            int sel;
            int n;
            sel = $urandom_range(0, 9);
            n = (sel == 0) ? 0 : (sel == 9) ? $urandom_range(9, 40) : $urandom_range(1, 8);
            cmd(2'($urandom_range(0, 3)), n);
            repeat ($urandom_range(0, 12)) @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                @(posedge clk);
                reset_now();
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expected cycles left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
